// File: rtl/cache_pkg.sv
// Shared constants and the response layout for the set-associative tag lookup stage.
// Widths are derived from the geometry so the controller and this stage agree on field sizes.
package cache_pkg;

    localparam int CACHE_WAYS      = 4;
    localparam int CACHE_SETS      = 16;
    localparam int CACHE_TAG_WIDTH = 8;

    // A single-entry dimension still needs a one-bit index to stay a legal vector.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CACHE_SET_W = index_width(CACHE_SETS);
    localparam int CACHE_WAY_W = index_width(CACHE_WAYS);

    typedef enum logic {
        REQ_LOOKUP = 1'b0,
        REQ_ALLOC  = 1'b1
    } req_kind_e;

    typedef struct packed {
        logic                   valid;
        logic                   hit;
        logic                   filled;
        logic [CACHE_WAY_W-1:0] way;
        logic [0:CACHE_WAYS-1]  match;
    } cache_resp_t;

endpackage

// File: rtl/cache_tag_lookup_or.sv
// N-input OR reduction that turns the per-way match vector into a single hit flag.
module cache_tag_lookup_or #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] data,
    output logic            result
);

    assign result = |data;

endmodule

// File: rtl/cache_tag_lookup.sv
// Set-associative tag store with registered per-way match output and round-robin fill.
// One request per cycle; the output register is a single-entry stage without skid buffer.
module cache_tag_lookup
    import cache_pkg::*;
#(
    parameter int WAYS      = CACHE_WAYS,
    parameter int SETS      = CACHE_SETS,
    parameter int TAG_WIDTH = CACHE_TAG_WIDTH
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic                         REQ_FILL,
    input  logic [index_width(SETS)-1:0] REQ_SET,
    input  logic [TAG_WIDTH-1:0]         REQ_TAG,
    input  logic                         FLUSH,
    output logic                         RESP_VALID,
    input  logic                         RESP_READY,
    output logic [0:WAYS-1]              RESP_MATCH,
    output logic                         RESP_HIT,
    output logic                         RESP_FILLED,
    output logic [index_width(WAYS)-1:0] RESP_WAY
);

    localparam int SET_W = index_width(SETS);
    localparam int WAY_W = index_width(WAYS);

    logic [TAG_WIDTH-1:0] tag_q    [SETS][WAYS];
    logic [0:WAYS-1]      valid_q  [SETS];
    logic [WAY_W-1:0]     victim_q [SETS];

    logic [0:WAYS-1]  cmp_match;
    logic             cmp_hit;
    logic [WAY_W-1:0] cmp_way;
    logic [WAY_W-1:0] victim;
    logic [0:WAYS-1]  fill_onehot;
    logic             accept;
    logic             fill_miss;
    req_kind_e        req_kind;

    assign REQ_READY = !RESP_VALID || RESP_READY;
    assign accept    = REQ_VALID && REQ_READY && !RESET;
    assign req_kind  = REQ_FILL ? REQ_ALLOC : REQ_LOOKUP;
    assign victim    = victim_q[REQ_SET];

    always_comb begin
        cmp_match = '0;
        for (int i = 0; i < WAYS; i++) begin
            cmp_match[i] = valid_q[REQ_SET][i] && (tag_q[REQ_SET][i] == REQ_TAG);
        end
    end

    // Walk downward so the lowest matching way wins if duplicates ever exist.
    always_comb begin
        cmp_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (cmp_match[i]) begin
                cmp_way = WAY_W'(i);
            end
        end
    end

    always_comb begin
        fill_onehot         = '0;
        fill_onehot[victim] = 1'b1;
    end

    assign cmp_hit   = |cmp_match;
    assign fill_miss = (req_kind == REQ_ALLOC) && !cmp_hit;

    // Valid bits, victim pointers and the response register share one reset domain.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]  <= '0;
                victim_q[s] <= '0;
            end
            RESP_VALID  <= 1'b0;
            RESP_MATCH  <= '0;
            RESP_FILLED <= 1'b0;
            RESP_WAY    <= '0;
        end else begin
            if (FLUSH) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end else if (accept && fill_miss) begin
                valid_q[REQ_SET][victim] <= 1'b1;
            end

            // The pointer advances even when a coincident flush discards the write.
            if (accept && fill_miss) begin
                victim_q[REQ_SET] <= victim + WAY_W'(1);
            end

            if (accept) begin
                RESP_VALID  <= 1'b1;
                RESP_MATCH  <= fill_miss ? fill_onehot : cmp_match;
                RESP_FILLED <= fill_miss;
                RESP_WAY    <= fill_miss ? victim : cmp_way;
            end else if (RESP_READY) begin
                RESP_VALID <= 1'b0;
            end
        end
    end

    // Tag contents are deliberately left out of reset; valid bits alone gate them.
    always_ff @(posedge CLK) begin
        if (!RESET && !FLUSH && accept && fill_miss) begin
            tag_q[REQ_SET][victim] <= REQ_TAG;
        end
    end

    cache_tag_lookup_or #(
        .SIZE(WAYS)
    ) u_hit_or (
        .data  (RESP_MATCH),
        .result(RESP_HIT)
    );

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed plus randomized checks of cache_tag_lookup against a per-set reference model.
module tb_cache_tag_lookup;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_fill;
    logic [3:0] req_set;
    logic [7:0] req_tag;
    logic       flush;
    logic       resp_valid;
    logic       resp_ready;
    logic [0:3] resp_match;
    logic       resp_hit;
    logic       resp_filled;
    logic [1:0] resp_way;

    int errors = 0;
    int checks = 0;

    // Reference model: each set holds up to four valid tags plus its next victim slot.
    int m_tag    [16][4];
    bit m_valid  [16][4];
    int m_victim [16];

    logic [0:3] e_match;
    bit         e_filled;
    int         e_way;
    logic [0:3] held_match;
    int         held_way;

    cache_tag_lookup dut (
        .CLK        (clk),
        .RESET      (reset),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_FILL   (req_fill),
        .REQ_SET    (req_set),
        .REQ_TAG    (req_tag),
        .FLUSH      (flush),
        .RESP_VALID (resp_valid),
        .RESP_READY (resp_ready),
        .RESP_MATCH (resp_match),
        .RESP_HIT   (resp_hit),
        .RESP_FILLED(resp_filled),
        .RESP_WAY   (resp_way)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_victim[s] = 0;
            for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
        end
    endtask

    task automatic model_request(input bit fill, input int set, input int tag, input bit fl);
        bit found = 0;
        e_match  = '0;
        e_way    = 0;
        e_filled = 0;
        for (int w = 0; w < 4; w++) begin
            if (m_valid[set][w] && m_tag[set][w] == tag) begin
                e_match[w] = 1'b1;
                if (!found) e_way = w;
                found = 1;
            end
        end
        if (fill && !found) begin
            e_way         = m_victim[set];
            e_match       = '0;
            e_match[e_way] = 1'b1;
            e_filled      = 1;
            m_victim[set] = (m_victim[set] + 1) % 4;
            if (!fl) begin
                m_tag[set][e_way]   = tag;
                m_valid[set][e_way] = 1;
            end
        end
        if (fl) begin
            for (int s = 0; s < 16; s++)
                for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
        end
    endtask

    task automatic check_response(input string name);
        check_output({name, "_valid"},  32'(resp_valid),  32'(1'b1));
        check_output({name, "_match"},  32'(resp_match),  32'(e_match));
        check_output({name, "_hit"},    32'(resp_hit),    32'(|e_match));
        check_output({name, "_filled"}, 32'(resp_filled), 32'(e_filled));
        check_output({name, "_way"},    32'(resp_way),    32'(e_way));
    endtask

    // Called at posedge+1; leaves the request driven so successive calls run back-to-back.
    task automatic apply_stimulus(input string name, input bit fill, input int set, input int tag,
                                  input bit fl);
        req_valid = 1'b1;
        req_fill  = fill;
        req_set   = 4'(set);
        req_tag   = 8'(tag);
        flush     = fl;
        model_request(fill, set, tag, fl);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_response(name);
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_fill   = 1'b0;
        req_set    = '0;
        req_tag    = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_req_ready", 32'(req_ready), 32'd1);
        check_output("reset_resp_valid", 32'(resp_valid), 32'd0);
        check_output("reset_resp_match", 32'(resp_match), 32'd0);
        check_output("reset_resp_hit", 32'(resp_hit), 32'd0);
        check_output("reset_resp_filled", 32'(resp_filled), 32'd0);
        check_output("reset_resp_way", 32'(resp_way), 32'd0);
        reset = 1'b0;
        idle_cycle();

        $display("[TB] cold lookup");
        apply_stimulus("cold_lookup", 0, 3, 8'h5A, 0);
        check_output("cold_lookup_const", 32'(resp_match), 32'd0);

        $display("[TB] round-robin fill of set 3");
        apply_stimulus("fill_11", 1, 3, 8'h11, 0);
        apply_stimulus("fill_22", 1, 3, 8'h22, 0);
        apply_stimulus("fill_33", 1, 3, 8'h33, 0);
        apply_stimulus("fill_44", 1, 3, 8'h44, 0);
        apply_stimulus("fill_55", 1, 3, 8'h55, 0);
        check_output("wrap_way_const", 32'(resp_way), 32'd0);
        apply_stimulus("lookup_11", 0, 3, 8'h11, 0);
        check_output("evicted_hit_const", 32'(resp_hit), 32'd0);
        apply_stimulus("lookup_55", 0, 3, 8'h55, 0);
        check_output("lookup_55_const", 32'(resp_match), 32'b1000);

        $display("[TB] duplicate fill of set 2");
        apply_stimulus("dup_first", 1, 2, 8'h22, 0);
        apply_stimulus("dup_second", 1, 2, 8'h22, 0);
        check_output("dup_second_filled_const", 32'(resp_filled), 32'd0);
        apply_stimulus("dup_next_alloc", 1, 2, 8'h23, 0);
        check_output("dup_victim_const", 32'(resp_way), 32'd1);

        $display("[TB] back-pressure");
        held_match = e_match;
        held_way   = e_way;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_fill   = 1'b1;
        req_set    = 4'd4;
        req_tag    = 8'h4B;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_output("stall_req_ready", 32'(req_ready), 32'd0);
            check_output("stall_resp_valid", 32'(resp_valid), 32'd1);
            check_output("stall_resp_match", 32'(resp_match), 32'(held_match));
            check_output("stall_resp_way", 32'(resp_way), 32'(held_way));
        end
        resp_ready = 1'b1;
        apply_stimulus("released", 1, 4, 8'h4B, 0);

        $display("[TB] flush with fill");
        apply_stimulus("flush_fill", 1, 1, 8'h7F, 1);
        apply_stimulus("after_flush_7f", 0, 1, 8'h7F, 0);
        apply_stimulus("after_flush_55", 0, 3, 8'h55, 0);
        apply_stimulus("after_flush_22", 0, 2, 8'h22, 0);
        apply_stimulus("after_flush_4b", 0, 4, 8'h4B, 0);

        $display("[TB] reset with response pending");
        apply_stimulus("pre_reset_fill", 1, 5, 8'h99, 0);
        resp_ready = 1'b0;
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_fill   = 1'b1;
        req_set    = 4'd5;
        req_tag    = 8'h66;
        @(posedge clk);
        #1;
        check_output("reset_drop_valid", 32'(resp_valid), 32'd0);
        check_output("reset_req_ready_held", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        resp_ready = 1'b1;
        model_reset();
        idle_cycle();
        check_output("post_reset_idle", 32'(resp_valid), 32'd0);
        apply_stimulus("post_reset_99", 0, 5, 8'h99, 0);
        apply_stimulus("post_reset_66", 0, 5, 8'h66, 0);
        apply_stimulus("post_reset_alloc", 1, 5, 8'h66, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            int tag_pool;
            tag_pool = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) idle_cycle();
            apply_stimulus("random", bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                           8'h20 + tag_pool, $urandom_range(0, 24) == 0);
        end
        idle_cycle();
        check_output("final_idle_valid", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_tag_lookup.md
# cache_tag_lookup

Set-associative tag store and lookup stage feeding the cache hit reduction. It accepts a lookup or fill request per cycle (set index plus tag), compares the tag against every way of that set, and registers a per-way match vector. That vector is reduced to a single hit flag by the N-input OR stage directly downstream. Fill requests also install the tag into a round-robin victim way, so the cache controller can allocate on miss.

## Interface

Parameters:
- WAYS, 4: associativity; power of two, 2..16.
- SETS, 16: number of sets; power of two.
- TAG_WIDTH, 8: tag bits per way.

Ports:
- CLK, in, 1: single clock; all state changes on the rising edge.
- RESET, in, 1: synchronous, active-high reset.
- REQ_VALID, in, 1: request present.
- REQ_READY, out, 1: stage can accept a request.
- REQ_FILL, in, 1: 1 = fill (allocate on miss), 0 = lookup only.
- REQ_SET, in, log2(SETS): set index.
- REQ_TAG, in, TAG_WIDTH: tag to compare or install.
- FLUSH, in, 1: clear all valid bits.
- RESP_VALID, out, 1: response held in the output register.
- RESP_READY, in, 1: consumer takes the response.
- RESP_MATCH, out, [0:WAYS-1]: per-way match vector, bit i = way i; this vector feeds the OR reduction.
- RESP_HIT, out, 1: OR of RESP_MATCH.
- RESP_FILLED, out, 1: 1 = this response installed a new tag.
- RESP_WAY, out, log2(WAYS): index of the matching or filled way; 0 when there is no match.

## Operation

- State: tag array [SETS][WAYS] x TAG_WIDTH; valid bits [SETS][WAYS]; per-set victim pointer of log2(WAYS) bits; output register (RESP_*).
- Accept: a request is accepted when REQ_VALID && REQ_READY.
- REQ_READY = !RESP_VALID || RESP_READY. This is a single-entry pipeline with no skid buffer.
- Compare: way i matches when valid[set][i] && tag[set][i] == REQ_TAG. The compare runs on state from before the current edge.
- Lookup (REQ_FILL=0): register the match vector. RESP_FILLED=0. No state change.
- Fill with a hit: behaves exactly like a lookup. No write, and the victim pointer is unchanged.
- Fill with a miss:
  - Write REQ_TAG into way v = victim[set] and set valid[set][v].
  - Advance victim[set] to (v+1) mod WAYS.
  - Response: RESP_MATCH = one-hot(v), RESP_FILLED=1, RESP_WAY=v.
- Multiple matches: these cannot arise through fills. If they occur anyway, RESP_WAY = lowest matching index and RESP_MATCH shows all matching bits.
- Back-pressure: while RESP_VALID && !RESP_READY, the output register holds and no request is accepted.
- FLUSH:
  - Clears all valid bits at the edge. Victim pointers are kept.
  - If FLUSH coincides with an accepted request, the request compares against pre-flush state and its response is delivered normally.
  - A same-cycle fill write is discarded: flush wins, and the victim pointer still advances.
- RESET clears all valid bits, victim pointers, RESP_VALID, RESP_MATCH, RESP_FILLED and RESP_WAY. Tag contents are not reset. A response in flight is dropped.

## Timing

- Latency: a request accepted at edge N has its response visible from edge N+1.
- Throughput: one request per cycle while RESP_READY=1.
- Read-after-fill: a fill at edge N is visible to a request accepted at edge N+1.
- Reset values: REQ_READY=1 (it is combinational from RESP_VALID=0); all RESP_* outputs 0.
- RESP_HIT is combinational from the RESP_MATCH register, adding zero cycles.
- RESET held high overrides FLUSH and any request. REQ_READY still reads 1, but nothing is accepted during reset.
- Victim pointer wraps from WAYS-1 to 0.

## Structure

- Package cache_pkg holds:
  - the clog2-based width constants for the set index and way index;
  - the response field layout shared with the controller.
- The match reduction is the existing N-input OR sub-module, instantiated with SIZE=WAYS: RESP_MATCH in, RESP_HIT out.
- Tag/valid storage, the victim pointers and the output register stay inside this block.

## Test plan

- Reset, then lookup set 3 tag 0x5A -> response next cycle with RESP_MATCH=0000, RESP_HIT=0, RESP_WAY=0.
- Fill set 3 with tags 0x11, 0x22, 0x33, 0x44, then a fifth fill 0x55:
  - the first four fill ways 0..3 (RESP_FILLED=1 each);
  - 0x55 wraps to way 0;
  - a later lookup of 0x11 misses and a lookup of 0x55 returns MATCH=1000, WAY=0.
- Fill set 2 tag 0x22 twice back-to-back -> first response FILLED=1, WAY=0; second response HIT=1, FILLED=0, WAY=0; victim pointer is 1.
- RESP_READY=0 for 3 cycles with REQ_VALID held -> REQ_READY=0, response stable. On release, the held request is accepted and answered on the next cycle.
- FLUSH together with a fill of set 1 tag 0x7F that would miss:
  - the response reads FILLED=1, WAY=v;
  - the next lookup of 0x7F misses;
  - all earlier-filled tags miss.
- Assert RESET while RESP_VALID=1 -> RESP_VALID=0 next edge; prior tags all miss afterwards.
